// File: rtl/psel_rr_multi.sv
// K-grant round-robin selector with a registered rotating priority pointer.
// Define PSEL_RR_REG_OUT_EN to register the grant outputs (one cycle of latency).
module psel_rr_multi #(
    parameter int N     = 8,
    parameter int K     = 2,
    parameter int DIR   = 0,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_en,
    input  logic                      i_stall,
    input  logic [N-1:0]              i_req,
    output logic [N-1:0]              o_gnt,
    output logic [K-1:0][N-1:0]       o_gnt_bus,
    output logic [K-1:0][IDX_W-1:0]   o_gnt_idx,
    output logic [K-1:0]              o_gnt_valid,
    output logic [IDX_W-1:0]          o_ptr
);

    logic [IDX_W-1:0]            r_ptr;
    logic [N-1:0]                w_req_en;
    logic [N-1:0]                w_gnt;
    logic [K-1:0][N-1:0]         w_bus;
    logic [K-1:0][IDX_W-1:0]     w_idx;
    logic [K-1:0]                w_valid;
    logic [IDX_W-1:0]            w_last;
    logic [IDX_W-1:0]            w_ptr_nxt;

    // Position j steps from p in the search direction, wrapping at N rather than 2^IDX_W.
    function automatic logic [IDX_W-1:0] scan_pos(input logic [IDX_W-1:0] p, input int j);
        logic [IDX_W:0] s;
        if (DIR == 0) s = {1'b0, p} + (IDX_W+1)'(j);
        else          s = {1'b0, p} + (IDX_W+1)'(N - j);
        if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
        return s[IDX_W-1:0];
    endfunction

    assign w_req_en = i_en ? i_req : '0;

    always_comb begin
        logic [N-1:0]     v_taken;
        logic             v_found;
        logic [IDX_W-1:0] v_pos;
        w_bus   = '0;
        w_idx   = '0;
        w_valid = '0;
        v_taken = '0;
        v_found = 1'b0;
        v_pos   = '0;
        for (int k = 0; k < K; k++) begin
            v_found = 1'b0;
            for (int j = 0; j < N; j++) begin
                v_pos = scan_pos(r_ptr, j);
                if (!v_found && w_req_en[v_pos] && !v_taken[v_pos]) begin
                    v_found        = 1'b1;
                    w_bus[k][v_pos] = 1'b1;
                    w_idx[k]       = v_pos;
                    w_valid[k]     = 1'b1;
                end
            end
            v_taken = v_taken | w_bus[k];
        end
        w_gnt = v_taken;
    end

    always_comb begin
        w_last = '0;
        for (int k = 0; k < K; k++) begin
            if (w_valid[k]) w_last = w_idx[k];
        end
    end

    // The next pointer sits just past the last granted index, so skipped requesters lead next time.
    assign w_ptr_nxt = scan_pos(w_last, 1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                               r_ptr <= '0;
        else if (i_en && !i_stall && |w_valid)     r_ptr <= w_ptr_nxt;
    end

    assign o_ptr = r_ptr;

`ifdef PSEL_RR_REG_OUT_EN
    logic [N-1:0]                r_gnt;
    logic [K-1:0][N-1:0]         r_bus;
    logic [K-1:0][IDX_W-1:0]     r_idx;
    logic [K-1:0]                r_valid;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_gnt   <= '0;
            r_bus   <= '0;
            r_idx   <= '0;
            r_valid <= '0;
        end else begin
            r_gnt   <= w_gnt;
            r_bus   <= w_bus;
            r_idx   <= w_idx;
            r_valid <= w_valid;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_bus   = r_bus;
    assign o_gnt_idx   = r_idx;
    assign o_gnt_valid = r_valid;
`else
    // Grants are silenced while reset is held, even though the pointer already reads 0.
    assign o_gnt       = i_reset ? '0 : w_gnt;
    assign o_gnt_bus   = i_reset ? '0 : w_bus;
    assign o_gnt_idx   = i_reset ? '0 : w_idx;
    assign o_gnt_valid = i_reset ? '0 : w_valid;
`endif

endmodule

// File: tb/tb_psel_rr_multi.sv
// Directed bench for psel_rr_multi: DIR=0 (N=8,K=2), DIR=1 (N=8,K=2), and N=5,K=3 instances.
module tb_psel_rr_multi;

    logic clk = 1'b0;
    logic rst, en, stall;
    logic [7:0] req0, req1;
    logic [4:0] req2;

    logic [7:0]       gnt0, gnt1;
    logic [1:0][7:0]  bus0, bus1;
    logic [1:0][2:0]  idx0, idx1;
    logic [1:0]       val0, val1;
    logic [2:0]       ptr0, ptr1;
    logic [4:0]       gnt2;
    logic [2:0][4:0]  bus2;
    logic [2:0][2:0]  idx2;
    logic [2:0]       val2;
    logic [2:0]       ptr2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psel_rr_multi #(.N(8), .K(2), .DIR(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_stall(stall), .i_req(req0),
        .o_gnt(gnt0), .o_gnt_bus(bus0), .o_gnt_idx(idx0), .o_gnt_valid(val0), .o_ptr(ptr0));

    psel_rr_multi #(.N(8), .K(2), .DIR(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_stall(stall), .i_req(req1),
        .o_gnt(gnt1), .o_gnt_bus(bus1), .o_gnt_idx(idx1), .o_gnt_valid(val1), .o_ptr(ptr1));

    psel_rr_multi #(.N(5), .K(3), .DIR(0)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_stall(stall), .i_req(req2),
        .o_gnt(gnt2), .o_gnt_bus(bus2), .o_gnt_idx(idx2), .o_gnt_valid(val2), .o_ptr(ptr2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 8'hFF;
        #1;
        checks++; if (gnt0 !== 8'h00) begin failures++; $display("FAIL rst_gnt got=%h exp=%h", gnt0, 8'h00); end
        checks++; if (val0 !== 2'b00) begin failures++; $display("FAIL rst_valid got=%b exp=%b", val0, 2'b00); end
        checks++; if (idx0 !== 6'd0) begin failures++; $display("FAIL rst_idx got=%h exp=0", idx0); end
        checks++; if (ptr0 !== 3'd0) begin failures++; $display("FAIL rst_ptr got=%0d exp=0", ptr0); end
        step();
        checks++; if (ptr0 !== 3'd0) begin failures++; $display("FAIL rst_ptr_held got=%0d exp=0", ptr0); end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        logic [2:0] exp_ptr [5];
        logic [7:0] exp_gnt [5];
        exp_ptr = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
        exp_gnt = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
        req0 = 8'hFF;
        #1;
        checks++; if (idx0[0] !== 3'd0 || idx0[1] !== 3'd1) begin failures++; $display("FAIL rot_idx got=%0d,%0d exp=0,1", idx0[0], idx0[1]); end
        checks++; if (val0 !== 2'b11) begin failures++; $display("FAIL rot_valid got=%b exp=11", val0); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (ptr0 !== exp_ptr[c]) begin failures++; $display("FAIL rot_ptr c%0d got=%0d exp=%0d", c, ptr0, exp_ptr[c]); end
            checks++; if (gnt0 !== exp_gnt[c]) begin failures++; $display("FAIL rot_gnt c%0d got=%h exp=%h", c, gnt0, exp_gnt[c]); end
            step();
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        req0 = 8'h20;
        #1;
        checks++; if (gnt0 !== 8'h20) begin failures++; $display("FAIL wrap_pre_gnt got=%h exp=20", gnt0); end
        step();
        checks++; if (ptr0 !== 3'd6) begin failures++; $display("FAIL wrap_ptr6 got=%0d exp=6", ptr0); end
        req0 = 8'h40;
        step();
        checks++; if (ptr0 !== 3'd7) begin failures++; $display("FAIL wrap_ptr7 got=%0d exp=7", ptr0); end
        req0 = 8'h81;
        #1;
        checks++; if (gnt0 !== 8'h81) begin failures++; $display("FAIL wrap_gnt got=%h exp=81", gnt0); end
        checks++; if (idx0[0] !== 3'd7 || idx0[1] !== 3'd0) begin failures++; $display("FAIL wrap_idx got=%0d,%0d exp=7,0", idx0[0], idx0[1]); end
        checks++; if (bus0[0] !== 8'h80 || bus0[1] !== 8'h01) begin failures++; $display("FAIL wrap_bus got=%h,%h exp=80,01", bus0[0], bus0[1]); end
        step();
        checks++; if (ptr0 !== 3'd1) begin failures++; $display("FAIL wrap_next_ptr got=%0d exp=1", ptr0); end
    endtask

    task automatic test_few_requests();
        req0 = 8'h10;
        #1;
        checks++; if (val0 !== 2'b01) begin failures++; $display("FAIL few_valid got=%b exp=01", val0); end
        checks++; if (idx0[0] !== 3'd4 || idx0[1] !== 3'd0) begin failures++; $display("FAIL few_idx got=%0d,%0d exp=4,0", idx0[0], idx0[1]); end
        checks++; if (bus0[1] !== 8'h00) begin failures++; $display("FAIL few_bus1 got=%h exp=00", bus0[1]); end
        step();
        checks++; if (ptr0 !== 3'd5) begin failures++; $display("FAIL few_ptr got=%0d exp=5", ptr0); end
        req0 = 8'h00;
        #1;
        checks++; if (gnt0 !== 8'h00 || val0 !== 2'b00) begin failures++; $display("FAIL none_gnt got=%h/%b exp=00/00", gnt0, val0); end
        step();
        checks++; if (ptr0 !== 3'd5) begin failures++; $display("FAIL none_ptr got=%0d exp=5", ptr0); end
    endtask

    task automatic test_en_stall();
        stall = 1'b1;
        req0 = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (gnt0 !== 8'h60) begin failures++; $display("FAIL stall_gnt c%0d got=%h exp=60", c, gnt0); end
            step();
            checks++; if (ptr0 !== 3'd5) begin failures++; $display("FAIL stall_ptr c%0d got=%0d exp=5", c, ptr0); end
        end
        en = 1'b0;
        #1;
        checks++; if (gnt0 !== 8'h00 || val0 !== 2'b00) begin failures++; $display("FAIL en_stall_gnt got=%h/%b exp=00/00", gnt0, val0); end
        step();
        stall = 1'b0;
        #1;
        checks++; if (gnt0 !== 8'h00 || val0 !== 2'b00) begin failures++; $display("FAIL en0_gnt got=%h/%b exp=00/00", gnt0, val0); end
        step();
        checks++; if (ptr0 !== 3'd5) begin failures++; $display("FAIL en0_ptr got=%0d exp=5", ptr0); end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        req0 = 8'hFF;
        #1;
        checks++; if (ptr0 !== 3'd5 || gnt0 !== 8'h60) begin failures++; $display("FAIL arst_pre got=%0d/%h exp=5/60", ptr0, gnt0); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ptr0 !== 3'd0) begin failures++; $display("FAIL arst_ptr got=%0d exp=0", ptr0); end
        checks++; if (gnt0 !== 8'h00 || val0 !== 2'b00) begin failures++; $display("FAIL arst_gnt got=%h/%b exp=00/00", gnt0, val0); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (ptr0 !== 3'd0 || gnt0 !== 8'h03) begin failures++; $display("FAIL arst_rel0 got=%0d/%h exp=0/03", ptr0, gnt0); end
        step();
        checks++; if (ptr0 !== 3'd2 || gnt0 !== 8'h0C) begin failures++; $display("FAIL arst_rel1 got=%0d/%h exp=2/0C", ptr0, gnt0); end
    endtask

    task automatic test_dir1();
        req0 = 8'h00;
        pulse_reset();
        req1 = 8'hFF;
        #1;
        checks++; if (gnt1 !== 8'h81) begin failures++; $display("FAIL dir1_gnt0 got=%h exp=81", gnt1); end
        checks++; if (idx1[0] !== 3'd0 || idx1[1] !== 3'd7) begin failures++; $display("FAIL dir1_idx got=%0d,%0d exp=0,7", idx1[0], idx1[1]); end
        checks++; if (bus1[0] !== 8'h01 || bus1[1] !== 8'h80 || val1 !== 2'b11) begin failures++; $display("FAIL dir1_bus got=%h,%h/%b exp=01,80/11", bus1[0], bus1[1], val1); end
        step();
        checks++; if (ptr1 !== 3'd6 || gnt1 !== 8'h60) begin failures++; $display("FAIL dir1_c1 got=%0d/%h exp=6/60", ptr1, gnt1); end
        step();
        checks++; if (ptr1 !== 3'd4) begin failures++; $display("FAIL dir1_ptr got=%0d exp=4", ptr1); end
        req1 = 8'h00;
    endtask

    task automatic test_nonpow2();
        pulse_reset();
        req2 = 5'h1F;
        #1;
        checks++; if (gnt2 !== 5'h07 || val2 !== 3'b111) begin failures++; $display("FAIL np2_gnt0 got=%h/%b exp=07/111", gnt2, val2); end
        step();
        checks++; if (ptr2 !== 3'd3 || gnt2 !== 5'h19) begin failures++; $display("FAIL np2_c1 got=%0d/%h exp=3/19", ptr2, gnt2); end
        checks++; if (idx2[0] !== 3'd3 || idx2[1] !== 3'd4 || idx2[2] !== 3'd0) begin failures++; $display("FAIL np2_idx got=%0d,%0d,%0d exp=3,4,0", idx2[0], idx2[1], idx2[2]); end
        checks++; if (bus2[2] !== 5'h01) begin failures++; $display("FAIL np2_bus2 got=%h exp=01", bus2[2]); end
        step();
        checks++; if (ptr2 !== 3'd1 || gnt2 !== 5'h0E) begin failures++; $display("FAIL np2_c2 got=%0d/%h exp=1/0E", ptr2, gnt2); end
        req2 = 5'h00;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        stall = 1'b0;
        req0  = 8'h00;
        req1  = 8'h00;
        req2  = 5'h00;
        test_reset();
        test_rotation();
        test_wrap();
        test_few_requests();
        test_en_stall();
        test_async_reset();
        test_dir1();
        test_nonpow2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
